// File: rtl/serial_alu.sv
// Nibble-serial ALU: one 4-bit slice per clock, LS nibble first, with the
// carry chained between nibbles through a register. Valid/ready on both sides.
module serial_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_d1,
    input  logic [WIDTH-1:0] in_d2,
    input  logic [4:0]       in_cmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_all_ones,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int ACC_W = (WIDTH > 4) ? WIDTH - 4 : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("serial_alu: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   d1_reg;
    // Operand B pre-inverted, with carry_in parked above the MSB so the
    // shift-right "right" input of the top bit falls out of the same shift.
    logic [WIDTH:0]     b_reg;
    logic               cd_reg;
    logic [1:0]         sel_reg;
    logic               carry_reg;
    logic [NIB_W-1:0]   nib_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [WIDTH-1:0]   out_res_reg;
    logic               out_carry_reg;
    logic               out_zero_reg;
    logic               out_all_ones_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               busy_reg;

    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         right_nib;
    logic [3:0]         g;
    logic [3:0]         p;
    logic [4:0]         c;
    logic [3:0]         m;
    logic [3:0]         nib_res;
    logic [WIDTH-1:0]   res_full;
    logic               last_nib;

    assign a_nib     = d1_reg[3:0];
    assign b_nib     = b_reg[3:0];
    assign right_nib = b_reg[4:1];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign g[gi] = a_nib[gi] & b_nib[gi];
            assign p[gi] = a_nib[gi] | b_nib[gi];
            assign m[gi] = (sel_reg == 2'b00) ? (~g[gi] & p[gi]) :
                           (sel_reg == 2'b01) ? g[gi] :
                           (sel_reg == 2'b10) ? p[gi] : right_nib[gi];
            assign nib_res[gi] = m[gi] ^ (c[gi] & ~cd_reg);
        end
    endgenerate

    // Carry-lookahead across the four bits of the current nibble.
    assign c[0] = carry_reg;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);

    // Nibbles enter at the top of the accumulator and drift down, so after
    // the last nibble the concatenation is the full result in place.
    generate
        if (NIB == 1) begin : g_one_nib
            assign res_full = nib_res;
        end else begin : g_multi_nib
            assign res_full = {nib_res, acc_reg};
        end
    endgenerate

    assign last_nib = (nib_reg == NIB_W'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            d1_reg           <= '0;
            b_reg            <= '0;
            cd_reg           <= 1'b0;
            sel_reg          <= 2'b00;
            carry_reg        <= 1'b0;
            nib_reg          <= '0;
            acc_reg          <= '0;
            out_res_reg      <= '0;
            out_carry_reg    <= 1'b0;
            out_zero_reg     <= 1'b0;
            out_all_ones_reg <= 1'b0;
            in_ready_reg     <= 1'b1;
            out_valid_reg    <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        d1_reg       <= in_d1;
                        b_reg        <= {in_cmd[4], in_d2 ^ {WIDTH{in_cmd[3]}}};
                        cd_reg       <= in_cmd[2];
                        sel_reg      <= in_cmd[1:0];
                        carry_reg    <= in_cmd[4];
                        nib_reg      <= '0;
                        acc_reg      <= '0;
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    d1_reg    <= d1_reg >> 4;
                    b_reg     <= b_reg >> 4;
                    carry_reg <= c[4];
                    nib_reg   <= nib_reg + NIB_W'(1);
                    acc_reg   <= ACC_W'(res_full >> 4);
                    if (last_nib) begin
                        state_reg        <= DONE;
                        out_valid_reg    <= 1'b1;
                        out_res_reg      <= res_full;
                        out_carry_reg    <= c[4] & ~cd_reg;
                        out_zero_reg     <= (res_full == '0);
                        out_all_ones_reg <= &res_full;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign out_res      = out_res_reg;
    assign out_carry    = out_carry_reg;
    assign out_zero     = out_zero_reg;
    assign out_all_ones = out_all_ones_reg;
    assign busy         = busy_reg;

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Multi-cycle, width-parametrised successor to the 4-bit combinational ALU slice.
- Processes a WIDTH-bit operation one 4-bit nibble per clock, least-significant nibble first, chaining carry between nibbles through a register.
- Uses the same 5-bit command encoding and per-bit slice semantics as the existing ALU, so 8/16/32-bit datapaths can reuse one narrow slice.
- Sits between the register-file read stage and writeback, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NIB (localparam), WIDTH/4: number of nibble cycles per operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- in_d1  in  WIDTH  operand A.
- in_d2  in  WIDTH  operand B.
- in_cmd  in  5  {carry_in, b_inv, carry_disable, sel[1:0]}: ADD=00000, SUB=11000, XOR=x0100, XNOR=x1100, COMP=01000, AND=x0101, OR=x0110, RSHFT=00111.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_res  out  WIDTH  result.
- out_carry  out  1  carry out of the top nibble; inverted-borrow convention for SUB/COMP.
- out_zero  out  1  out_res == 0.
- out_all_ones  out  1  out_res == all ones; after COMP this means A == B.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_res=0, out_carry=0, out_zero=0, out_all_ones=0.
  - All internal registers cleared.
- Reset mid-operation abandons the operation immediately; no partial result is ever presented.
- States and transitions:
  - IDLE: in_ready=1. On the edge with in_valid=1, latch in_d1, in_d2, in_cmd; set carry register to cmd.carry_in; nib=0; go to RUN.
  - RUN: in_ready=0. Each edge computes nibble nib and writes it into result[4*nib+3 : 4*nib]. Update carry register with that nibble's carry out; nib++. At nib==NIB-1, go to DONE.
  - DONE: out_valid=1; outputs stable. On the edge with out_ready=1, go to IDLE. With out_ready=0, hold indefinitely.
- Input and latching rules:
  - in_valid is ignored outside IDLE. No back-to-back acceptance: one operation per NIB+2 cycles minimum.
  - Latched operands are unaffected by input changes after acceptance.
- Latency: out_valid rises exactly NIB edges after the acceptance edge (WIDTH=16: 4; WIDTH=4: 1).
- Per-bit slice, bit i of the current nibble:
  - b = d2[i] ^ b_inv; g = d1[i] & b; p = d1[i] | b.
  - m = sel 00: ~g & p; sel 01: g; sel 10: p; sel 11: right.
  - res = m ^ (c_i & ~carry_disable).
  - Carry chain c_{i+1} = g | (p & c_i), carry-lookahead within the nibble. c_0 of nibble 0 is cmd.carry_in; c_0 of later nibbles is the carry register.
- RSHFT right bit: right = b at global bit position+1. For the global MSB, right = cmd.carry_in, so 10111 shifts a 1 in. The carry register is irrelevant for RSHFT.
- Flags:
  - out_carry = top-nibble carry when carry_disable=0, else 0.
  - SUB: out_carry = 1 iff A >= B unsigned.
  - COMP (A-B-1): out_carry = 1 iff A > B. If out_all_ones=1, then A == B.
  - out_zero and out_all_ones are registered and valid whenever out_valid=1.
- ADD with A==B yields A<<1 (SLL) with out_carry = A[WIDTH-1].
- Arithmetic is modulo 2^WIDTH.

Test Plan:
- WIDTH=16, ADD, A=0x00FF, B=0x0001 -> out_res=0x0100, out_carry=0, out_zero=0, out_valid 4 cycles after acceptance; then ADD 0xFFFF+0x0001 -> 0x0000, carry=1, zero=1.
- SUB 0x1234-0x1235 -> 0xFFFF, out_carry=0; SUB 0x1235-0x1234 -> 0x0001, out_carry=1; COMP 0x5A5A vs 0x5A5A -> out_all_ones=1; COMP 0x8000 vs 0x7FFF -> out_carry=1.
- RSHFT (00111) B=0x8001 -> 0x4000; RSHFT (10111) B=0x8001 -> 0xC000 (nibble-boundary bits cross correctly); XOR/XNOR/AND/OR on 0xF0A5, 0x3C3C -> 0xCC99, 0x3366, 0x3024, 0xFCBD, all with out_carry=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge, then the pending request is accepted.
- Reset: assert rst_n=0 during RUN at nib=2 -> all outputs 0, in_ready=1 immediately (asynchronous); the next operation after release produces a correct result with no carry contamination.
- Parameter sweep: WIDTH=4, 8, 32 with random cmd/operands vs a reference model -> bit-exact res/carry/flags, latency = WIDTH/4.
